// File: rtl/poly_voice_allocator.sv
// Polyphonic voice allocator: assigns MIDI note-on/off events to NUM_VOICES voice slots
// with retrigger, lowest-free allocation, oldest-voice stealing and all-notes-off.
module poly_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8,
  parameter int STEAL_MODE = 0
) (
  input  logic                    inCLK_50MHZ,
  input  logic                    inReset,
  input  logic                    inEventValid,
  output logic                    outEventReady,
  input  logic                    inNoteOn,
  input  logic [6:0]              inNote,
  input  logic [6:0]              inVelocity,
  input  logic                    inAllNotesOff,
  output logic [7*NUM_VOICES-1:0] outVoiceNote,
  output logic [7*NUM_VOICES-1:0] outVoiceVelocity,
  output logic [NUM_VOICES-1:0]   outVoiceGate,
  output logic [NUM_VOICES-1:0]   outVoiceTrigger,
  output logic                    outStolen,
  output logic                    outDropped,
  output logic [4:0]              outActiveCount
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  function automatic logic [4:0] count_gates(input logic [NUM_VOICES-1:0] g);
    logic [4:0] c;
    c = '0;
    for (int v = 0; v < NUM_VOICES; v++) c = c + {4'd0, g[v]};
    return c;
  endfunction

  state_t                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   ev_on_q;
  logic [6:0]             ev_note_q, ev_vel_q;
  logic                   match_vld_q, match_vld_d, free_vld_q, free_vld_d, old_vld_q, old_vld_d;
  logic [IDX_W-1:0]       match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d;
  logic [AGE_W-1:0]       old_age_q, old_age_d;
  logic [6:0]             note_q [NUM_VOICES];
  logic [6:0]             note_d [NUM_VOICES];
  logic [6:0]             vel_q  [NUM_VOICES];
  logic [6:0]             vel_d  [NUM_VOICES];
  logic [AGE_W-1:0]       age_q  [NUM_VOICES];
  logic [AGE_W-1:0]       age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0]  gate_q, gate_d, trig_q, trig_d;
  logic                   stolen_q, stolen_d, dropped_q, dropped_d;
  logic [4:0]             count_q, count_d;
  logic                   accept;
  logic                   load;
  logic [IDX_W-1:0]       tgt;

  assign accept = inEventValid & ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    note_d      = note_q;
    vel_d       = vel_q;
    age_d       = age_q;
    gate_d      = gate_q;
    trig_d      = '0;
    stolen_d    = 1'b0;
    dropped_d   = 1'b0;
    load        = 1'b0;
    tgt         = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = SCAN;
          idx_d       = '0;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
          old_vld_d   = 1'b0;
        end
      end
      SCAN: begin
        if (gate_q[idx_q] && (note_q[idx_q] == ev_note_q) && !match_vld_q) begin
          match_vld_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!gate_q[idx_q] && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (gate_q[idx_q] && (!old_vld_q || (age_q[idx_q] > old_age_q))) begin
          old_vld_d = 1'b1;
          old_idx_d = idx_q;
          old_age_d = age_q[idx_q];
        end
        if (idx_q == LAST_IDX) state_d = COMMIT;
        else                   idx_d   = idx_q + 1'b1;
      end
      COMMIT: begin
        state_d = IDLE;
        if (ev_on_q) begin
          if (match_vld_q) begin
            tgt  = match_idx_q;
            load = 1'b1;
          end else if (free_vld_q) begin
            tgt  = free_idx_q;
            load = 1'b1;
          end else if ((STEAL_MODE == 0) && old_vld_q) begin
            tgt      = old_idx_q;
            load     = 1'b1;
            stolen_d = 1'b1;
          end else begin
            dropped_d = 1'b1;
          end
        end else if (match_vld_q) begin
          gate_d[match_idx_q] = 1'b0;
        end
        if (load) begin
          for (int v = 0; v < NUM_VOICES; v++)
            if (gate_q[v] && (IDX_W'(v) != tgt)) age_d[v] = age_inc(age_q[v]);
          note_d[tgt] = ev_note_q;
          vel_d[tgt]  = ev_vel_q;
          gate_d[tgt] = 1'b1;
          age_d[tgt]  = '0;
          trig_d[tgt] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // All-notes-off aborts whatever is in flight, including a commit this cycle.
    if (inAllNotesOff) begin
      state_d   = IDLE;
      gate_d    = '0;
      trig_d    = '0;
      stolen_d  = 1'b0;
      dropped_d = 1'b0;
      note_d    = note_q;
      vel_d     = vel_q;
      age_d     = age_q;
    end
    ready_d = (state_d == IDLE);
    count_d = count_gates(gate_d);
  end

  always_ff @(posedge inCLK_50MHZ) begin
    if (inReset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      idx_q       <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      gate_q      <= '0;
      trig_q      <= '0;
      stolen_q    <= 1'b0;
      dropped_q   <= 1'b0;
      count_q     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        vel_q[v]  <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      idx_q       <= idx_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      gate_q      <= gate_d;
      trig_q      <= trig_d;
      stolen_q    <= stolen_d;
      dropped_q   <= dropped_d;
      count_q     <= count_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      age_q       <= age_d;
    end
  end

  always_ff @(posedge inCLK_50MHZ) begin
    if (accept) begin
      ev_on_q   <= inNoteOn && (inVelocity != 7'd0);
      ev_note_q <= inNote;
      ev_vel_q  <= inVelocity;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
    assign outVoiceNote[7*v +: 7]     = note_q[v];
    assign outVoiceVelocity[7*v +: 7] = vel_q[v];
  end

  assign outEventReady   = ready_q;
  assign outVoiceGate    = gate_q;
  assign outVoiceTrigger = trig_q;
  assign outStolen       = stolen_q;
  assign outDropped      = dropped_q;
  assign outActiveCount  = count_q;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Bench for poly_voice_allocator: a stealing and a dropping instance share stimulus and are
// compared against a transaction-level voice model using load timestamps for age.
module tb_poly_voice_allocator;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst, valid, non, anoff;
  logic [6:0] note, vel;
  logic              ready   [2];
  logic [7*NV-1:0]   vnote   [2];
  logic [7*NV-1:0]   vvel    [2];
  logic [NV-1:0]     gate    [2];
  logic [NV-1:0]     trig    [2];
  logic              stolen  [2];
  logic              dropped [2];
  logic [4:0]        cnt     [2];

  always #5 clk = ~clk;

  poly_voice_allocator #(.NUM_VOICES(NV), .AGE_W(8), .STEAL_MODE(0)) u_steal (
    .inCLK_50MHZ(clk), .inReset(rst), .inEventValid(valid), .outEventReady(ready[0]),
    .inNoteOn(non), .inNote(note), .inVelocity(vel), .inAllNotesOff(anoff),
    .outVoiceNote(vnote[0]), .outVoiceVelocity(vvel[0]), .outVoiceGate(gate[0]),
    .outVoiceTrigger(trig[0]), .outStolen(stolen[0]), .outDropped(dropped[0]),
    .outActiveCount(cnt[0]));

  poly_voice_allocator #(.NUM_VOICES(NV), .AGE_W(8), .STEAL_MODE(1)) u_drop (
    .inCLK_50MHZ(clk), .inReset(rst), .inEventValid(valid), .outEventReady(ready[1]),
    .inNoteOn(non), .inNote(note), .inVelocity(vel), .inAllNotesOff(anoff),
    .outVoiceNote(vnote[1]), .outVoiceVelocity(vvel[1]), .outVoiceGate(gate[1]),
    .outVoiceTrigger(trig[1]), .outStolen(stolen[1]), .outDropped(dropped[1]),
    .outActiveCount(cnt[1]));

  int vectors = 0;
  int miscompares = 0;

  int          mn    [2][NV];
  int          mv    [2][NV];
  int          stamp [2][NV];
  bit          mg    [2][NV];
  int          loads [2];
  logic [NV-1:0] etrig [2];
  bit          est   [2];
  bit          edr   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      loads[m] = 0; etrig[m] = '0; est[m] = 0; edr[m] = 0;
      for (int v = 0; v < NV; v++) begin
        mn[m][v] = 0; mv[m][v] = 0; stamp[m][v] = 0; mg[m][v] = 0;
      end
    end
  endfunction

  function automatic void model_all_off();
    for (int m = 0; m < 2; m++) begin
      etrig[m] = '0; est[m] = 0; edr[m] = 0;
      for (int v = 0; v < NV; v++) mg[m][v] = 0;
    end
  endfunction

  function automatic void clear_pulses();
    for (int m = 0; m < 2; m++) begin
      etrig[m] = '0; est[m] = 0; edr[m] = 0;
    end
  endfunction

  // Age = loads since this voice was (re)loaded, saturating at 255.
  function automatic int age_of(input int m, input int v);
    int d;
    d = loads[m] - stamp[m][v];
    return (d > 255) ? 255 : d;
  endfunction

  function automatic void model_event(input int m, input bit on, input int n, input int ve);
    int match, t, best;
    match = -1; t = -1; best = -1;
    etrig[m] = '0; est[m] = 0; edr[m] = 0;
    for (int v = 0; v < NV; v++)
      if (mg[m][v] && mn[m][v] == n && match < 0) match = v;
    if (on && ve != 0) begin
      if (match >= 0) t = match;
      else for (int v = 0; v < NV; v++) if (!mg[m][v] && t < 0) t = v;
      if (t < 0) begin
        if (m == 0) begin
          for (int v = 0; v < NV; v++)
            if (best < 0 || age_of(m, v) > age_of(m, best)) best = v;
          t = best;
          est[m] = 1;
        end else begin
          edr[m] = 1;
        end
      end
      if (t >= 0) begin
        loads[m]++;
        mn[m][t] = n; mv[m][t] = ve; mg[m][t] = 1; stamp[m][t] = loads[m];
        etrig[m][t] = 1'b1;
      end
    end else if (match >= 0) begin
      mg[m][match] = 0;
    end
  endfunction

  task automatic compare(input string tag);
    logic [7*NV-1:0] en, ev;
    logic [NV-1:0]   eg;
    int              ec;
    for (int m = 0; m < 2; m++) begin
      en = '0; ev = '0; eg = '0; ec = 0;
      for (int v = 0; v < NV; v++) begin
        en[7*v +: 7] = 7'(mn[m][v]);
        ev[7*v +: 7] = 7'(mv[m][v]);
        eg[v] = mg[m][v];
        ec += int'(mg[m][v]);
      end
      check($sformatf("%s/m%0d/gate", tag, m),    32'(gate[m]),    32'(eg));
      check($sformatf("%s/m%0d/count", tag, m),   32'(cnt[m]),     32'(ec));
      check($sformatf("%s/m%0d/note", tag, m),    32'(vnote[m]),   32'(en));
      check($sformatf("%s/m%0d/vel", tag, m),     32'(vvel[m]),    32'(ev));
      check($sformatf("%s/m%0d/trig", tag, m),    32'(trig[m]),    32'(etrig[m]));
      check($sformatf("%s/m%0d/stolen", tag, m),  32'(stolen[m]),  32'(est[m]));
      check($sformatf("%s/m%0d/dropped", tag, m), 32'(dropped[m]), 32'(edr[m]));
      check($sformatf("%s/m%0d/ready", tag, m),   32'(ready[m]),   32'd1);
    end
  endtask

  // abort_k: edge (0 = accept edge) at which inAllNotesOff is sampled; -1 = none.
  task automatic do_event(input bit on, input int n, input int ve, input int abort_k);
    @(negedge clk);
    for (int m = 0; m < 2; m++) check($sformatf("pre/m%0d/ready", m), 32'(ready[m]), 32'd1);
    valid = 1'b1; non = on; note = 7'(n); vel = 7'(ve); anoff = (abort_k == 0);
    @(posedge clk); #1;
    valid = 1'b0; anoff = 1'b0;
    if (abort_k == 0) begin
      model_all_off();
      compare("abort_accept");
      return;
    end
    for (int c = 1; c <= NV + 1; c++) begin
      @(negedge clk);
      anoff = (c == abort_k);
      @(posedge clk); #1;
      anoff = 1'b0;
      if (c == abort_k) begin
        model_all_off();
        compare("abort");
        return;
      end
      if (c == 1)
        for (int m = 0; m < 2; m++) check($sformatf("busy/m%0d/ready", m), 32'(ready[m]), 32'd0);
    end
    for (int m = 0; m < 2; m++) model_event(m, on, n, ve);
    compare("commit");
    @(posedge clk); #1;
    clear_pulses();
    compare("settle");
  endtask

  task automatic all_off_pulse();
    @(negedge clk);
    anoff = 1'b1;
    @(posedge clk); #1;
    anoff = 1'b0;
    model_all_off();
    compare("alloff");
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; non = 1'b0; note = '0; vel = '0; anoff = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare("reset");
    @(negedge clk);
    rst = 1'b0;

    do_event(1, 60, 100, -1);
    check("t2/voice0_note", 32'(vnote[0][6:0]), 32'd60);
    do_event(1, 64, 80, -1);
    do_event(1, 67, 70, -1);
    do_event(1, 71, 60, -1);
    do_event(1, 74, 55, -1);
    check("t3/steal_voice0", 32'(vnote[0][6:0]), 32'd74);
    check("t3/drop_voice0", 32'(vnote[1][6:0]), 32'd60);
    do_event(1, 64, 50, -1);
    do_event(1, 64, 0, -1);
    check("t5/note1_kept", 32'(vnote[0][13:7]), 32'd64);
    do_event(1, 80, 90, -1);
    do_event(1, 90, 33, 2);
    do_event(1, 91, 34, 0);
    do_event(1, 92, 35, NV + 1);

    // Two held voices saturate their ages; the tie must go to the lower index.
    all_off_pulse();
    do_event(1, 60, 10, -1);
    do_event(1, 62, 11, -1);
    do_event(0, 60, 0, -1);
    do_event(1, 60, 12, -1);
    for (int i = 0; i < 300; i++) begin
      do_event(1, 61, 20, -1);
      do_event(0, 61, 20, -1);
    end
    do_event(1, 61, 21, -1);
    do_event(1, 63, 22, -1);
    do_event(1, 70, 23, -1);

    for (int i = 0; i < 300; i++) begin
      bit on;
      int n, ve, ak;
      on = ($urandom_range(3) != 0);
      n  = 60 + $urandom_range(7);
      ve = ($urandom_range(7) == 0) ? 0 : 1 + $urandom_range(126);
      ak = ($urandom_range(15) == 0) ? $urandom_range(NV + 1) : -1;
      do_event(on, n, ve, ak);
    end

    // Reset in the middle of a scan clears everything.
    @(negedge clk);
    valid = 1'b1; non = 1'b1; note = 7'd99; vel = 7'd99;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    compare("reset_mid");
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
